// File: rtl/button_conditioner_pkg.sv
// Shared constants and key state encoding for the button conditioner.
package button_conditioner_pkg;

  // 20 ms at a 50 MHz clock
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

  typedef enum logic [1:0] {
    KEY_IDLE         = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_PRESSED      = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_t;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_filter.sv
// One-bit debounce: 2-flop synchronizer, saturating stability counter, stable level.
// A clean edge reaches o_stable DEBOUNCE_CYCLES+2 clocks after it is first sampled.
module debounce_filter
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_pending,
  output logic o_update
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_pending;
  logic          w_update;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pending = r_sync2 ^ r_stable;
  assign w_update  = w_pending && (r_cnt == CNT_DONE);

  // Any sample that agrees with the stable level throws away the partial count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stable <= RESET_LEVEL;
      r_cnt    <= '0;
    end else if (w_update) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else if (!w_pending) begin
      r_cnt    <= '0;
    end else if (r_cnt < CNT_DONE) begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign o_stable  = r_stable;
  assign o_pending = w_pending;
  assign o_update  = w_update;

endmodule

// File: rtl/button_conditioner.sv
// Debounces N_KEYS active-low push-buttons (press pulse + held level) and N_SW slide switches.
// Every output is a flop; a clean edge shows up DEBOUNCE_CYCLES+2 clocks after first sampling.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned N_SW            = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [N_KEYS-1:0] i_key_n,
  input  logic [N_SW-1:0]   i_sw,
  output logic [N_KEYS-1:0] o_key_press,
  output logic [N_KEYS-1:0] o_key_level,
  output logic [N_SW-1:0]   o_sw_stable,
  output logic              o_sw_changed
);

  logic [N_KEYS-1:0] w_key_pending;
  logic [N_KEYS-1:0] w_key_update;
  logic [N_KEYS-1:0] w_key_stable_unused;
  logic [N_SW-1:0]   w_sw_update;
  logic [N_SW-1:0]   w_sw_pending_unused;
  logic              r_sw_changed;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_state_t r_state;
    logic       r_press;
    logic       r_level;

    debounce_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b1)
    ) u_filter (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_raw     (i_key_n[k]),
      .o_stable  (w_key_stable_unused[k]),
      .o_pending (w_key_pending[k]),
      .o_update  (w_key_update[k])
    );

    // The filter counts the candidate; the FSM tracks direction so only presses pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_state <= KEY_IDLE;
        r_press <= 1'b0;
        r_level <= 1'b0;
      end else begin
        r_press <= 1'b0;
        case (r_state)
          KEY_IDLE: begin
            if (w_key_pending[k]) r_state <= KEY_PRESS_WAIT;
          end
          KEY_PRESS_WAIT: begin
            if (w_key_update[k]) begin
              r_state <= KEY_PRESSED;
              r_press <= 1'b1;
              r_level <= 1'b1;
            end else if (!w_key_pending[k]) begin
              r_state <= KEY_IDLE;
            end
          end
          KEY_PRESSED: begin
            if (w_key_pending[k]) r_state <= KEY_RELEASE_WAIT;
          end
          KEY_RELEASE_WAIT: begin
            if (w_key_update[k]) begin
              r_state <= KEY_IDLE;
              r_level <= 1'b0;
            end else if (!w_key_pending[k]) begin
              r_state <= KEY_PRESSED;
            end
          end
        endcase
      end
    end

    assign o_key_press[k] = r_press;
    assign o_key_level[k] = r_level;
  end

  for (genvar s = 0; s < N_SW; s++) begin : g_sw
    debounce_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b0)
    ) u_filter (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_raw     (i_sw[s]),
      .o_stable  (o_sw_stable[s]),
      .o_pending (w_sw_pending_unused[s]),
      .o_update  (w_sw_update[s])
    );
  end

  // Registered on the same edge that loads o_sw_stable, so the two line up.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sw_changed <= 1'b0;
    end else begin
      r_sw_changed <= |w_sw_update;
    end
  end

  assign o_sw_changed = r_sw_changed;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with an 8-cycle debounce window.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] key_n;
  logic [3:0] sw;
  logic [1:0] key_press;
  logic [1:0] key_level;
  logic [3:0] sw_stable;
  logic       sw_changed;

  int tests      = 0;
  int fails      = 0;
  int press_seen = 0;
  int chg_seen   = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES (8),
    .N_KEYS          (2),
    .N_SW            (4)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_key_n      (key_n),
    .i_sw         (sw),
    .o_key_press  (key_press),
    .o_key_level  (key_level),
    .o_sw_stable  (sw_stable),
    .o_sw_changed (sw_changed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, sampling on the falling edge and tallying pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      press_seen += $countones(key_press);
      chg_seen   += int'(sw_changed);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    key_n   = 2'b11;
    sw      = 4'b0000;
    step(3);
    chk("rst_press",   32'(key_press),  32'(2'b00));
    chk("rst_level",   32'(key_level),  32'(2'b00));
    chk("rst_sw",      32'(sw_stable),  32'(4'b0000));
    chk("rst_changed", 32'(sw_changed), 32'(1'b0));
    reset_n    = 1'b1;
    press_seen = 0;
    chg_seen   = 0;
    step(5);
    chk("idle_quiet", 32'(press_seen + chg_seen), 32'd0);

    // Clean press on key 0, held with a 7-cycle bounce in the middle
    key_n      = 2'b10;
    press_seen = 0;
    step(10);
    chk("k0_early_press", 32'(key_press), 32'(2'b00));
    chk("k0_early_level", 32'(key_level), 32'(2'b00));
    step(1);
    chk("k0_press",       32'(key_press), 32'(2'b01));
    chk("k0_level",       32'(key_level), 32'(2'b01));
    step(1);
    chk("k0_pulse_width", 32'(key_press), 32'(2'b00));
    press_seen = 0;
    step(10);
    key_n = 2'b11;
    step(7);
    key_n = 2'b10;
    step(20);
    chk("k0_hold_no_refire", 32'(press_seen), 32'd0);
    chk("k0_hold_level",     32'(key_level),  32'(2'b01));

    key_n      = 2'b11;
    press_seen = 0;
    step(10);
    chk("k0_rel_early",    32'(key_level),  32'(2'b01));
    step(1);
    chk("k0_rel_level",    32'(key_level),  32'(2'b00));
    chk("k0_rel_no_pulse", 32'(press_seen), 32'd0);
    step(2);

    // Key 1 bouncing every 3 cycles, then settling low
    press_seen = 0;
    for (int i = 0; i < 10; i++) begin
      key_n[1] = i[0];
      step(3);
    end
    key_n[1] = 1'b0;
    step(10);
    chk("k1_bounce_no_press", 32'(press_seen), 32'd0);
    chk("k1_bounce_level",    32'(key_level),  32'(2'b00));
    step(1);
    chk("k1_press", 32'(key_press), 32'(2'b10));
    chk("k1_level", 32'(key_level), 32'(2'b10));
    press_seen = 0;
    step(20);
    chk("k1_single_pulse", 32'(press_seen), 32'd0);
    key_n = 2'b11;
    step(12);
    chk("k1_released", 32'(key_level), 32'(2'b00));

    // Two switch bits change together, then short glitches either way
    chg_seen = 0;
    sw       = 4'b1010;
    step(10);
    chk("sw_early",      32'(sw_stable),  32'(4'b0000));
    step(1);
    chk("sw_stable",     32'(sw_stable),  32'(4'b1010));
    chk("sw_changed",    32'(sw_changed), 32'(1'b1));
    step(1);
    chk("sw_chg_width",  32'(sw_changed), 32'(1'b0));
    chk("sw_one_pulse",  32'(chg_seen),   32'd1);
    chg_seen = 0;
    sw       = 4'b1011;
    step(5);
    sw = 4'b1010;
    step(3);
    sw = 4'b1000;
    step(5);
    sw = 4'b1010;
    step(12);
    chk("sw_glitch_no_chg", 32'(chg_seen),  32'd0);
    chk("sw_glitch_value",  32'(sw_stable), 32'(4'b1010));

    // Asynchronous reset 6 cycles into a key press
    key_n      = 2'b10;
    press_seen = 0;
    step(6);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_press",   32'(key_press),  32'(2'b00));
    chk("arst_level",   32'(key_level),  32'(2'b00));
    chk("arst_sw",      32'(sw_stable),  32'(4'b0000));
    chk("arst_changed", 32'(sw_changed), 32'(1'b0));
    step(2);
    reset_n    = 1'b1;
    press_seen = 0;
    chg_seen   = 0;
    step(10);
    chk("post_rst_no_press", 32'(press_seen), 32'd0);
    chk("post_rst_sw_early", 32'(sw_stable),  32'(4'b0000));
    step(1);
    chk("post_rst_press",    32'(key_press),  32'(2'b01));
    chk("post_rst_sw",       32'(sw_stable),  32'(4'b1010));
    chk("post_rst_changed",  32'(sw_changed), 32'(1'b1));

    // Both keys pressed on the same cycle, then released together
    key_n = 2'b11;
    step(12);
    chk("both_idle", 32'(key_level), 32'(2'b00));
    key_n      = 2'b00;
    press_seen = 0;
    step(11);
    chk("both_press",       32'(key_press),  32'(2'b11));
    chk("both_level",       32'(key_level),  32'(2'b11));
    chk("both_pulse_count", 32'(press_seen), 32'd2);
    step(1);
    chk("both_pulse_width", 32'(key_press),  32'(2'b00));
    key_n      = 2'b11;
    press_seen = 0;
    step(10);
    chk("both_rel_early",    32'(key_level),  32'(2'b11));
    step(1);
    chk("both_rel_level",    32'(key_level),  32'(2'b00));
    chk("both_rel_no_pulse", 32'(press_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
